// File: rtl/m_axi_write.sv
// AXI4-Lite write master that programs a six-register DMA setup sequence
// (MM2S/S2MM control, addresses and lengths) for each accepted command.
module m_axi_write #(
  parameter int GLOB_ADDR_WIDTH      = 32,
  parameter int GLOB_DATA_WIDTH      = 32,
  parameter int BANK1_SRC_ADDR_WIDTH = 32,
  parameter int BANK1_SRC_SIZE_WIDTH = 26,
  parameter int BANK1_DST_ADDR_WIDTH = 32,
  parameter int BANK1_DST_SIZE_WIDTH = 26,
  parameter logic [GLOB_ADDR_WIDTH-1:0] DMA_BASE_ADDR = '0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [BANK1_SRC_ADDR_WIDTH-1:0] cmd_src_addr,
  input  logic [BANK1_SRC_SIZE_WIDTH-1:0] cmd_src_size,
  input  logic [BANK1_DST_ADDR_WIDTH-1:0] cmd_dst_addr,
  input  logic [BANK1_DST_SIZE_WIDTH-1:0] cmd_dst_size,
  output logic                            done,
  output logic                            error,
  output logic                            busy,
  output logic [GLOB_ADDR_WIDTH-1:0]      M_AXI_AWADDR,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [GLOB_DATA_WIDTH-1:0]      M_AXI_WDATA,
  output logic [GLOB_DATA_WIDTH/8-1:0]    M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY
);

  typedef enum logic [1:0] {IDLE, WRITE, RESP, FIN} state_t;

  state_t                          state_q, state_d;
  logic [2:0]                      idx_q, idx_d;
  logic [BANK1_SRC_ADDR_WIDTH-1:0] src_addr_q, src_addr_d;
  logic [BANK1_SRC_SIZE_WIDTH-1:0] src_size_q, src_size_d;
  logic [BANK1_DST_ADDR_WIDTH-1:0] dst_addr_q, dst_addr_d;
  logic [BANK1_DST_SIZE_WIDTH-1:0] dst_size_q, dst_size_d;
  logic                            awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic                            error_q, error_d;
  logic [GLOB_ADDR_WIDTH-1:0]      awaddr_q, awaddr_d;
  logic [GLOB_DATA_WIDTH-1:0]      wdata_q, wdata_d;

  logic [2:0]                      ent_idx;
  logic [7:0]                      ent_off;
  logic [GLOB_DATA_WIDTH-1:0]      ent_data;
  logic                            aw_ok, w_ok;

  // Entry about to be issued: 0 on accept, idx+1 when leaving RESP.
  // Entry 0 is a constant, so stale latched fields at accept are harmless.
  assign ent_idx = (state_q == RESP) ? idx_q + 3'd1 : 3'd0;

  always_comb begin
    ent_off  = 8'h00;
    ent_data = '0;
    case (ent_idx)
      3'd0:    begin ent_off = 8'h00; ent_data = GLOB_DATA_WIDTH'(1); end
      3'd1:    begin ent_off = 8'h18; ent_data = GLOB_DATA_WIDTH'(src_addr_q); end
      3'd2:    begin ent_off = 8'h28; ent_data = GLOB_DATA_WIDTH'(src_size_q); end
      3'd3:    begin ent_off = 8'h30; ent_data = GLOB_DATA_WIDTH'(1); end
      3'd4:    begin ent_off = 8'h48; ent_data = GLOB_DATA_WIDTH'(dst_addr_q); end
      3'd5:    begin ent_off = 8'h58; ent_data = GLOB_DATA_WIDTH'(dst_size_q); end
      default: begin ent_off = 8'h00; ent_data = '0; end
    endcase
  end

  // In WRITE a low valid means that channel has already handshaken.
  assign aw_ok = !awvalid_q || M_AXI_AWREADY;
  assign w_ok  = !wvalid_q  || M_AXI_WREADY;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    src_addr_d = src_addr_q;
    src_size_d = src_size_q;
    dst_addr_d = dst_addr_q;
    dst_size_d = dst_size_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    error_d    = error_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        src_addr_d = cmd_src_addr;
        src_size_d = cmd_src_size;
        dst_addr_d = cmd_dst_addr;
        dst_size_d = cmd_dst_size;
        idx_d      = 3'd0;
        error_d    = 1'b0;
        awaddr_d   = DMA_BASE_ADDR + GLOB_ADDR_WIDTH'(ent_off);
        wdata_d    = ent_data;
        awvalid_d  = 1'b1;
        wvalid_d   = 1'b1;
        state_d    = WRITE;
      end
      WRITE: begin
        awvalid_d = awvalid_q && !M_AXI_AWREADY;
        wvalid_d  = wvalid_q  && !M_AXI_WREADY;
        if (aw_ok && w_ok) state_d = RESP;
      end
      RESP: if (M_AXI_BVALID) begin
        if (M_AXI_BRESP != 2'b00) begin
          error_d = 1'b1;
          state_d = FIN;
        end else if (idx_q == 3'd5) begin
          state_d = FIN;
        end else begin
          idx_d     = ent_idx;
          awaddr_d  = DMA_BASE_ADDR + GLOB_ADDR_WIDTH'(ent_off);
          wdata_d   = ent_data;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = WRITE;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      src_addr_q <= '0;
      src_size_q <= '0;
      dst_addr_q <= '0;
      dst_size_q <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      error_q    <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      src_addr_q <= src_addr_d;
      src_size_q <= src_size_d;
      dst_addr_q <= dst_addr_d;
      dst_size_q <= dst_size_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      error_q    <= error_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign cmd_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == FIN);
  assign error         = error_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = (state_q == RESP);

endmodule

// File: tb/tb_m_axi_write.sv
// Directed bench for m_axi_write: a table of commands with slave behaviour
// knobs and hand-computed expected writes, done cycle and error flag.
module tb_m_axi_write;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_src_addr, cmd_dst_addr;
  logic [25:0] cmd_src_size, cmd_dst_size;
  logic        done, error, busy;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY;

  always #5 clk = ~clk;

  m_axi_write #(.DMA_BASE_ADDR(32'h4040_0000)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src_addr(cmd_src_addr), .cmd_src_size(cmd_src_size),
    .cmd_dst_addr(cmd_dst_addr), .cmd_dst_size(cmd_dst_size),
    .done(done), .error(error), .busy(busy),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY)
  );

  typedef struct {
    logic [31:0]       sa, da;
    logic [25:0]       ss, ds;
    int                aw_dly;   // cycles AWREADY is held off per write
    int                bad_idx;  // index answered with SLVERR, -1 none
    int                rst_idx;  // reset while in RESP at this index, -1 none
    bit                hold;     // keep cmd_valid high through the sequence
    int                exp_cyc;  // done cycle, accept cycle counted as 1
    int                exp_n;    // AW/W handshakes expected
    bit                exp_err;
    logic [5:0][31:0]  exp_data;
  } vec_t;

  int          n_cmp = 0, n_bad = 0;
  bit          prev_err = 1'b0;
  logic [5:0][31:0] exp_addr;
  vec_t        vecs[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] sa, input logic [25:0] ss,
                              input logic [31:0] da, input logic [25:0] ds,
                              input int aw_dly, input int bad_idx, input int rst_idx,
                              input bit hold, input int exp_cyc, input int exp_n,
                              input bit exp_err, input logic [5:0][31:0] exp_data);
    vec_t v;
    v.sa = sa; v.ss = ss; v.da = da; v.ds = ds;
    v.aw_dly = aw_dly; v.bad_idx = bad_idx; v.rst_idx = rst_idx; v.hold = hold;
    v.exp_cyc = exp_cyc; v.exp_n = exp_n; v.exp_err = exp_err; v.exp_data = exp_data;
    return v;
  endfunction

  task automatic run_cmd(input vec_t v);
    int   n_aw = 0, n_w = 0, n_b = 0, aw_cnt = 0;
    logic aw_hs_q = 1'b0, w_hs_q = 1'b0, aw_pend = 1'b0, awv_prev = 1'b0;
    logic [31:0] aw_prev = '0;
    bit   fin = 1'b0;
    @(negedge clk);
    chk("idle_ready", cmd_ready, 1'b1);
    chk("idle_busy", {busy, done, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, 5'b0);
    chk("error_hold", error, prev_err);
    cmd_src_addr = v.sa; cmd_src_size = v.ss;
    cmd_dst_addr = v.da; cmd_dst_size = v.ds;
    cmd_valid    = 1'b1;
    for (int c = 2; c < 300 && !fin; c++) begin
      @(negedge clk);
      if (!v.hold) cmd_valid = 1'b0;
      if (c == 2) chk("accept_busy_errclr", {busy, error}, 2'b10);
      chk("cmd_ready_busy", cmd_ready, 1'b0);
      if (aw_hs_q) chk("awvalid_drop", M_AXI_AWVALID, 1'b0);
      if (w_hs_q)  chk("wvalid_drop", M_AXI_WVALID, 1'b0);
      if (aw_pend) chk("awaddr_stable", {M_AXI_AWVALID, M_AXI_AWADDR}, {1'b1, aw_prev});
      if (M_AXI_AWVALID && !awv_prev) chk("valids_rise_together", M_AXI_WVALID, 1'b1);
      // slave inputs for the coming edge
      if (M_AXI_AWVALID) begin M_AXI_AWREADY = (aw_cnt >= v.aw_dly); aw_cnt++; end
      else M_AXI_AWREADY = 1'b0;
      M_AXI_WREADY = M_AXI_WVALID;
      M_AXI_BVALID = 1'b1;
      M_AXI_BRESP  = (n_b == v.bad_idx) ? 2'b10 : 2'b00;
      if (M_AXI_BREADY)
        chk("bready_after_aw_w", {M_AXI_AWVALID, M_AXI_WVALID, n_aw == n_b + 1, n_w == n_b + 1}, 4'b0011);
      if (M_AXI_BREADY && n_b == v.rst_idx) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cmd_valid = 1'b0;
        chk("rst_outputs", {busy, done, error, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, cmd_ready}, 7'b0000001);
        chk("rst_addr_data", {M_AXI_AWADDR, M_AXI_WDATA}, 64'h0);
        chk("rst_n_aw", n_aw, v.exp_n);
        prev_err = 1'b0;
        return;
      end
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin
        if (n_aw < 6) chk("awaddr", M_AXI_AWADDR, exp_addr[n_aw]);
        else chk("extra_aw", n_aw, 6);
        n_aw++; aw_cnt = 0;
      end
      if (M_AXI_WVALID && M_AXI_WREADY) begin
        if (n_w < 6) chk("wdata", {M_AXI_WSTRB, M_AXI_WDATA}, {4'hF, v.exp_data[n_w]});
        else chk("extra_w", n_w, 6);
        n_w++;
      end
      if (M_AXI_BREADY && M_AXI_BVALID) n_b++;
      if (done) begin
        chk("done_cycle", c, v.exp_cyc);
        chk("done_error", error, v.exp_err);
        chk("n_writes", {n_aw[15:0], n_w[15:0]}, {v.exp_n[15:0], v.exp_n[15:0]});
        prev_err = v.exp_err;
        fin = 1'b1;
      end
      aw_hs_q  = M_AXI_AWVALID && M_AXI_AWREADY;
      w_hs_q   = M_AXI_WVALID && M_AXI_WREADY;
      aw_pend  = M_AXI_AWVALID && !M_AXI_AWREADY;
      aw_prev  = M_AXI_AWADDR;
      awv_prev = M_AXI_AWVALID;
    end
    chk("done_seen", fin, 1'b1);
  endtask

  initial begin
    exp_addr = {32'h4040_0058, 32'h4040_0048, 32'h4040_0030,
                32'h4040_0028, 32'h4040_0018, 32'h4040_0000};
    //           sa            ss            da            ds           dly bad rst hold cyc n err  data {5..0}
    vecs[0] = mk(32'h1000_0000, 26'h100,     32'h2000_0000, 26'h80,      0, -1, -1, 0, 14, 6, 0,
                 {32'h80, 32'h2000_0000, 32'h1, 32'h100, 32'h1000_0000, 32'h1});
    vecs[1] = mk(32'h1000_0000, 26'h100,     32'h2000_0000, 26'h80,      3, -1, -1, 0, 32, 6, 0,
                 {32'h80, 32'h2000_0000, 32'h1, 32'h100, 32'h1000_0000, 32'h1});
    vecs[2] = mk(32'h1234_5678, 26'h55,      32'h8765_4321, 26'h66,      0,  2, -1, 0,  8, 3, 1,
                 {32'h66, 32'h8765_4321, 32'h1, 32'h55, 32'h1234_5678, 32'h1});
    vecs[3] = mk(32'h1000_0000, 26'h100,     32'h2000_0000, 26'h80,      0, -1, -1, 1, 14, 6, 0,
                 {32'h80, 32'h2000_0000, 32'h1, 32'h100, 32'h1000_0000, 32'h1});
    vecs[4] = mk(32'hDEAD_BEEF, 26'h3FF_FFFF, 32'hABCD_0000, 26'h3FF_FFFF, 0, -1, -1, 0, 14, 6, 0,
                 {32'h03FF_FFFF, 32'hABCD_0000, 32'h1, 32'h03FF_FFFF, 32'hDEAD_BEEF, 32'h1});
    vecs[5] = mk(32'h0BAD_0000, 26'h10,      32'h0BAD_1000, 26'h20,      0, -1,  3, 0,  0, 4, 0,
                 {32'h20, 32'h0BAD_1000, 32'h1, 32'h10, 32'h0BAD_0000, 32'h1});
    vecs[6] = mk(32'hFFFF_FFFF, 26'h0,       32'h0,         26'h1,       0, -1, -1, 0, 14, 6, 0,
                 {32'h1, 32'h0, 32'h1, 32'h0, 32'hFFFF_FFFF, 32'h1});

    reset = 1'b1; cmd_valid = 1'b0;
    cmd_src_addr = '0; cmd_src_size = '0; cmd_dst_addr = '0; cmd_dst_size = '0;
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", {busy, done, error, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, cmd_ready}, 7'b0000001);
    chk("reset_addr_data", {M_AXI_AWADDR, M_AXI_WDATA}, 64'h0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_cmd(vecs[i]);

    @(negedge clk);
    chk("final_idle", {busy, done, cmd_ready}, 3'b001);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/m_axi_write.md
M_AXI_WRITE -- requirements
Module: m_axi_write

Interface
REQ-001 The block SHALL expose the following parameters, one per line: name, default, meaning.
- GLOB_ADDR_WIDTH, 32, AXI address width.
- GLOB_DATA_WIDTH, 32, AXI data width.
- BANK1_SRC_ADDR_WIDTH, 32, source address width.
- BANK1_SRC_SIZE_WIDTH, 26, source byte-length width.
- BANK1_DST_ADDR_WIDTH, 32, destination address width.
- BANK1_DST_SIZE_WIDTH, 26, destination byte-length width.
- DMA_BASE_ADDR, 32'h0, DMA register base.

REQ-002 The block SHALL expose the following ports, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock; all logic on the rising edge.
- reset, in, 1, synchronous, active-high.
- cmd_valid, in, 1, command offered.
- cmd_ready, out, 1, command accepted.
- cmd_src_addr, in, BANK1_SRC_ADDR_WIDTH, MM2S source address.
- cmd_src_size, in, BANK1_SRC_SIZE_WIDTH, MM2S length.
- cmd_dst_addr, in, BANK1_DST_ADDR_WIDTH, S2MM destination address.
- cmd_dst_size, in, BANK1_DST_SIZE_WIDTH, S2MM length.
- done, out, 1, one-cycle pulse when a sequence completes or aborts.
- error, out, 1, valid with done; 1 = aborted on a bad BRESP.
- busy, out, 1, high whenever the state is not IDLE.
- M_AXI_AWADDR, out, GLOB_ADDR_WIDTH, write address.
- M_AXI_AWVALID, out, 1, write-address valid.
- M_AXI_AWREADY, in, 1, write-address ready.
- M_AXI_WDATA, out, GLOB_DATA_WIDTH, write data.
- M_AXI_WSTRB, out, GLOB_DATA_WIDTH/8, byte strobes, always all ones.
- M_AXI_WVALID, out, 1, write-data valid.
- M_AXI_WREADY, in, 1, write-data ready.
- M_AXI_BRESP, in, 2, write response code.
- M_AXI_BVALID, in, 1, response valid.
- M_AXI_BREADY, out, 1, response ready.

Function
REQ-003 The state machine SHALL have four states: IDLE, WRITE (AW/W outstanding), RESP (waiting for B), FIN (one cycle, asserts done).
REQ-004 In IDLE, cmd_ready SHALL be 1; when cmd_valid && cmd_ready, the block SHALL latch all four cmd_* fields, set index 0, and enter WRITE next cycle.
REQ-005 cmd_ready SHALL be 0 in every state other than IDLE; cmd_* inputs are ignored outside IDLE.
REQ-006 The write table SHALL be, as index: offset = data.
- 0: 0x00 = 1 (MM2S_DMACR run)
- 1: 0x18 = src_addr
- 2: 0x28 = src_size
- 3: 0x30 = 1 (S2MM_DMACR run)
- 4: 0x48 = dst_addr
- 5: 0x58 = dst_size
REQ-007 Table data SHALL be zero-extended to GLOB_DATA_WIDTH.
REQ-008 M_AXI_AWADDR SHALL be DMA_BASE_ADDR + offset, with modulo-2^GLOB_ADDR_WIDTH wrap.
REQ-009 On entering WRITE, AWVALID and WVALID SHALL both rise in the same cycle.
REQ-010 Each of AWVALID and WVALID SHALL drop the cycle after its own handshake (valid && ready), independently of the other.
REQ-011 AWADDR and WDATA SHALL be held stable while their valid is high.
REQ-012 Both valids SHALL be registered and SHALL never depend combinationally on either ready.
REQ-013 When both handshakes are complete, in the same cycle or in different cycles, the block SHALL enter RESP with BREADY = 1.
REQ-014 BREADY SHALL be 0 in every state except RESP.
REQ-015 In RESP, on BVALID with BRESP == 2'b00 and index < 5: increment index and return to WRITE next cycle.
REQ-016 In RESP, on BVALID with BRESP == 2'b00 and index == 5: go to FIN with error = 0.
REQ-017 In RESP, on BVALID with BRESP != 2'b00: go to FIN with error = 1 and issue no further table entries.
REQ-018 FIN SHALL pulse done for exactly one cycle, then return to IDLE.
REQ-019 error SHALL hold its value until the next accepted command clears it.
REQ-020 A BVALID arriving before both address and data handshakes complete SHALL be ignored (BREADY low); an interconnect is not permitted to do this.
REQ-021 Minimum latency with AWREADY, WREADY and BVALID always high SHALL be 1 (accept) + 6 × 2 cycles + 1 (FIN), so done is asserted in the 14th cycle after the accept edge.

Reset
REQ-022 reset SHALL be sampled only on the rising edge of clk.
REQ-023 When reset is sampled high, the block SHALL enter IDLE with index = 0, AWVALID = WVALID = BREADY = 0, done = 0, error = 0, busy = 0, AWADDR = 0 and WDATA = 0.
REQ-024 A reset asserted mid-sequence SHALL abandon the sequence without pulsing done; the next command SHALL restart at index 0.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- Base 0x4040_0000, src 0x1000_0000/0x100, dst 0x2000_0000/0x80, all readies high -> six writes at 0x40400000, 18, 28, 30, 48, 58 with data 1, 0x10000000, 0x100, 1, 0x20000000, 0x80; done in cycle 14; error = 0.
- AWREADY delayed 3 cycles, WREADY immediate on every write -> WVALID drops after 1 cycle; AWVALID holds with AWADDR stable; RESP is entered only after AW completes; table data is unchanged.
- BRESP = 2'b10 on index 2 -> done pulses with error = 1; no AWVALID ever for offsets 0x30–0x58.
- cmd_valid held high through a whole sequence -> exactly one command accepted; cmd_ready = 0 until IDLE, then the second command is accepted.
- reset pulsed while in RESP at index 3 -> all outputs return to reset values next cycle; no done pulse; the following command writes from offset 0x00.
- cmd_src_size = 26'h3FF_FFFF -> WDATA = 0x03FF_FFFF with the upper bits zero.
